// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI4-Lite single-outstanding master.
package axi_lite_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRESP,
    READ,
    RDATA,
    DONE
  } state_t;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [1:0] RESP_DECERR  = 2'b11;
  // A local abort is reported with the same code as a decode error.
  localparam logic [1:0] RESP_TIMEOUT = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi_lite_phase_timer.sv
// Per-phase cycle counter: cleared on every state change, counts while a
// phase is active, and flags the last allowed cycle of that phase.
module axi_lite_phase_timer #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] count;

  // Count cycles spent in the current phase; restart on each phase entry.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count <= '0;
    end else if (run) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = run && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/axi_lite_master.sv
// AXI4-Lite master bridging a local request/response port to one AXI
// transaction at a time, with a per-phase timeout that aborts a stuck slave.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  input  logic [1:0]              m_axi_bresp,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp
);

  state_t                  state, next_state;
  logic                    run_q;
  logic                    aw_done, w_done;
  logic                    phase_run, expired, abort;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]              resp_q;

  axi_lite_phase_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (next_state != state),
    .run    (phase_run),
    .expired(expired)
  );

  // State register; run_q keeps req_ready low until the first cycle after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      run_q <= 1'b0;
    end else begin
      state <= next_state;
      run_q <= 1'b1;
    end
  end

  // Next-state and channel handshake outputs; completion wins over expiry.
  always_comb begin
    next_state    = state;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    phase_run     = 1'b0;
    abort         = 1'b0;
    case (state)
      IDLE: begin
        req_ready = run_q;
        if (req_valid && run_q) next_state = req_write ? WRITE : READ;
      end
      WRITE: begin
        phase_run     = 1'b1;
        m_axi_awvalid = !aw_done;
        m_axi_wvalid  = !w_done;
        if ((aw_done || m_axi_awready) && (w_done || m_axi_wready)) begin
          next_state = WRESP;
        end else if (expired) begin
          next_state = DONE;
          abort      = 1'b1;
        end
      end
      WRESP: begin
        phase_run    = 1'b1;
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          next_state = DONE;
        end else if (expired) begin
          next_state = DONE;
          abort      = 1'b1;
        end
      end
      READ: begin
        phase_run     = 1'b1;
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) begin
          next_state = RDATA;
        end else if (expired) begin
          next_state = DONE;
          abort      = 1'b1;
        end
      end
      RDATA: begin
        phase_run    = 1'b1;
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) begin
          next_state = DONE;
        end else if (expired) begin
          next_state = DONE;
          abort      = 1'b1;
        end
      end
      DONE: begin
        rsp_valid  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Track which of AW and W have handshaken in the current write.
  always_ff @(posedge clk) begin
    if (!rst_n || state == IDLE) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (state == WRITE) begin
      if (m_axi_awvalid && m_axi_awready) aw_done <= 1'b1;
      if (m_axi_wvalid && m_axi_wready)   w_done  <= 1'b1;
    end
  end

  // Capture the request on accept so AXI payloads stay stable under stalls.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid && run_q) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      wstrb_q <= req_wstrb;
    end
  end

  // Response capture; values are held until the next transaction completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
      resp_q  <= RESP_OKAY;
    end else if (state == WRESP && m_axi_bvalid) begin
      rdata_q <= '0;
      resp_q  <= m_axi_bresp;
    end else if (state == RDATA && m_axi_rvalid) begin
      rdata_q <= m_axi_rdata;
      resp_q  <= m_axi_rresp;
    end else if (abort) begin
      rdata_q <= '0;
      resp_q  <= RESP_TIMEOUT;
    end
  end

  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = wstrb_q;
  assign m_axi_awprot = PROT_DEFAULT;
  assign m_axi_arprot = PROT_DEFAULT;
  assign rsp_rdata    = rdata_q;
  assign rsp_resp     = resp_q;

endmodule

// File: doc/axi_lite_master.md
AXI_LITE_MASTER -- requirements
Module: axi_lite_master
Interface
REQ-001 ADDR_WIDTH, 32, AXI address width.
REQ-002 DATA_WIDTH, 32, AXI data width; only 32 supported.
REQ-003 TIMEOUT_CYCLES, 256, max cycles spent in any one AXI phase before abort.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset; synchronous, active-low.
REQ-006 m_axi_awvalid  out  1  write address valid.
REQ-007 m_axi_awready  in  1  write address ready.
REQ-008 m_axi_awaddr  out  ADDR_WIDTH  write address.
REQ-009 m_axi_awprot  out  3  write protection, constant 3'b000.
REQ-010 m_axi_wvalid  out  1  write data valid.
REQ-011 m_axi_wready  in  1  write data ready.
REQ-012 m_axi_wdata  out  DATA_WIDTH  write data.
REQ-013 m_axi_wstrb  out  DATA_WIDTH/8  write byte strobes.
REQ-014 m_axi_bvalid  in  1  write response valid.
REQ-015 m_axi_bready  out  1  write response ready.
REQ-016 m_axi_bresp  in  2  write response code.
REQ-017 m_axi_arvalid  out  1  read address valid.
REQ-018 m_axi_arready  in  1  read address ready.
REQ-019 m_axi_araddr  out  ADDR_WIDTH  read address.
REQ-020 m_axi_arprot  out  3  read protection, constant 3'b000.
REQ-021 m_axi_rvalid  in  1  read data valid.
REQ-022 m_axi_rready  out  1  read data ready.
REQ-023 m_axi_rdata  in  DATA_WIDTH  read data.
REQ-024 m_axi_rresp  in  2  read response code.
REQ-025 req_valid  in  1  local request valid.
REQ-026 req_ready  out  1  local request ready; high only in IDLE.
REQ-027 req_write  in  1  1 = write, 0 = read.
REQ-028 req_addr  in  ADDR_WIDTH  absolute target address.
REQ-029 req_wdata  in  DATA_WIDTH  write data; ignored for reads.
REQ-030 req_wstrb  in  DATA_WIDTH/8  write strobes; ignored for reads.
REQ-031 rsp_valid  out  1  one-cycle pulse; transaction complete.
REQ-032 rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
REQ-033 rsp_resp  out  2  captured BRESP/RRESP; 2'b11 on timeout.
Function
REQ-034 FSM states: IDLE, WRITE, WRESP, READ, RDATA, DONE; exactly one transaction outstanding.
REQ-035 Accept on req_valid&req_ready: register addr, wdata, wstrb and write; go to WRITE or READ.
REQ-036 WRITE: assert awvalid and wvalid together; each drops independently on its own handshake (both may occur in the same cycle); when both are done, go to WRESP.
REQ-037 WRESP: assert bready; on bvalid, capture bresp and go to DONE. READ: assert arvalid until arready, then go to RDATA. RDATA: assert rready; on rvalid, capture rdata/rresp and go to DONE.
REQ-038 DONE: rsp_valid=1 for one cycle, then IDLE; with a zero-wait slave, rsp_valid is high 3 cycles after the accept edge.
REQ-039 awaddr, wdata, wstrb and araddr stay stable while the matching valid is high; a valid drops before its handshake only on timeout.
REQ-040 Phase counter clears on entering WRITE, WRESP, READ or RDATA and increments each cycle in that state; at TIMEOUT_CYCLES-1 without completion, drop all valid/ready, set rsp_resp=2'b11 and rsp_rdata=0, and go to DONE.
REQ-041 rsp_rdata and rsp_resp hold their values until the next DONE.
Reset
REQ-042 While rst_n=0: state IDLE; all AXI valid/ready outputs, rsp_valid, rsp_rdata, rsp_resp and counter at 0; req_ready=0, rising to 1 the first cycle after release; reset mid-transaction abandons it with no rsp_valid.
Structure
REQ-043 Package axi_lite_pkg SHALL hold the FSM state enum and the response codes OKAY=2'b00, SLVERR=2'b10, DECERR/TIMEOUT=2'b11; the phase counter SHALL be sub-module axi_lite_phase_timer.
Verification
REQ-044 Write 0x38 data 0x1 strb 0xF, zero-wait slave -> one AW and one W handshake carrying 0x38/0x1; rsp_valid 3 cycles after accept; rsp_resp 0.
REQ-045 awready delayed 4 cycles, wready immediate -> wvalid high 1 cycle; awvalid high 5 cycles with awaddr stable; exactly one B handshake.
REQ-046 Read 0x10, rvalid 2 cycles late with 0x12345678 -> rsp_rdata=0x12345678, rsp_resp=0, rready high until the handshake.
REQ-047 TIMEOUT_CYCLES=16, arready never asserted -> arvalid drops after 16 cycles; rsp_resp=2'b11, rsp_rdata=0; req_ready=1 next cycle.
REQ-048 req_valid held while busy -> no second accept until IDLE; rst_n low during WRESP -> bready=0 next cycle and no rsp_valid.
